// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/sequence FSM feeding opcode/argument to the ALU, with jump, halt and abort handling.
// Define INSTR_SEQUENCER_STEP_EN to add single-step ports (step, step_mode) and the STEP_WAIT state.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef ARG_WIDTH
`define ARG_WIDTH 8
`endif
module instr_sequencer #(
  parameter int PROG_LEN = 2**`ARG_WIDTH,
  parameter logic [`OPCODE_WIDTH-1:0] BUBBLE_OP = '1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
`ifdef INSTR_SEQUENCER_STEP_EN
  input  logic                               step,
  input  logic                               step_mode,
`endif
  input  logic [`OPCODE_WIDTH+`ARG_WIDTH-1:0] instr,
  input  logic                               jmp_ce,
  input  logic [`ARG_WIDTH-1:0]              jmp_addr,
  output logic [`ARG_WIDTH-1:0]              pc,
  output logic [`OPCODE_WIDTH-1:0]           opcode,
  output logic [`ARG_WIDTH-1:0]              argument,
  output logic                               running,
  output logic                               halted,
  output logic                               addr_err,
  output logic [15:0]                        retired
);
  typedef enum logic [1:0] {
    IDLE, RUN, HALT
`ifdef INSTR_SEQUENCER_STEP_EN
    , STEP_WAIT
`endif
  } state_t;
  state_t state, nxt;
  logic exec, launch, bad_jmp, self_jmp, last, stop;
  assign exec     = state == RUN && !abort;
  assign launch   = (state == IDLE || state == HALT) && start && !abort;
  assign bad_jmp  = jmp_ce && int'(jmp_addr) >= PROG_LEN;
  assign self_jmp = jmp_ce && jmp_addr == pc;
  assign last     = !jmp_ce && int'(pc) == PROG_LEN - 1;
  assign stop     = bad_jmp || self_jmp || last;
  assign opcode   = exec ? instr[`OPCODE_WIDTH+`ARG_WIDTH-1:`ARG_WIDTH] : BUBBLE_OP;
  assign argument = exec ? instr[`ARG_WIDTH-1:0] : '0;
  always_comb begin
    nxt = state;
    if (launch) nxt = RUN;
    if (state == RUN) nxt = (abort || stop) ? HALT : RUN;
`ifdef INSTR_SEQUENCER_STEP_EN
    if (exec && !stop && step_mode) nxt = STEP_WAIT;
    if (state == STEP_WAIT) nxt = abort ? HALT : step ? RUN : STEP_WAIT;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      addr_err <= 1'b0;
      retired  <= '0;
      running  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state   <= nxt;
      running <= nxt == RUN;
      halted  <= nxt == HALT;
      if (launch) begin
        pc       <= '0;
        addr_err <= 1'b0;
        retired  <= '0;
      end
      if (exec) begin
        retired <= &retired ? retired : retired + 16'd1;
        if (bad_jmp) addr_err <= 1'b1;
        pc <= stop ? pc : jmp_ce ? jmp_addr : pc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of sequencing, jumps, halts, abort and reset for instr_sequencer.
`timescale 1ns/1ps
module tb_instr_sequencer;
  logic clk = 1'b0, rst, start, abort, jmp_ce;
  logic [11:0] instr;
  logic [7:0] jmp_addr;
  logic [7:0] pc4, pc8, arg4, arg8;
  logic [3:0] op4, op8;
  logic run4, run8, hlt4, hlt8, err4, err8;
  logic [15:0] ret4, ret8;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  instr_sequencer #(.PROG_LEN(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .instr(instr),
    .jmp_ce(jmp_ce), .jmp_addr(jmp_addr), .pc(pc4), .opcode(op4), .argument(arg4),
    .running(run4), .halted(hlt4), .addr_err(err4), .retired(ret4)
  );
  instr_sequencer #(.PROG_LEN(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .instr(instr),
    .jmp_ce(jmp_ce), .jmp_addr(jmp_addr), .pc(pc8), .opcode(op8), .argument(arg8),
    .running(run8), .halted(hlt8), .addr_err(err8), .retired(ret8)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; jmp_ce = 1'b0; jmp_addr = 8'd0; instr = 12'h3C7;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_pc", pc4, 0);
    chk("reset_running", run4, 0);
    chk("reset_halted", hlt4, 0);
    chk("reset_err", err4, 0);
    chk("reset_retired", ret4, 0);
    chk("idle_opcode", op4, 4'hF);
    chk("idle_argument", arg4, 0);
    // linear program on the 4-word instance
    start = 1'b1; cyc(); start = 1'b0;
    chk("lin_running", run4, 1);
    chk("lin_pc0", pc4, 0);
    chk("lin_opcode", op4, 4'h3);
    chk("lin_argument", arg4, 8'hC7);
    cyc(); chk("lin_pc1", pc4, 1);
    cyc(); chk("lin_pc2", pc4, 2);
    cyc(); chk("lin_pc3", pc4, 3);
    cyc();
    chk("lin_halted", hlt4, 1);
    chk("lin_not_running", run4, 0);
    chk("lin_pc_hold", pc4, 3);
    chk("lin_retired", ret4, 4);
    chk("lin_err", err4, 0);
    chk("lin_halt_opcode", op4, 4'hF);
    chk("lin_u8_pc4", pc8, 4);
    rst = 1'b1; cyc(); rst = 1'b0;
    // taken jump on the 8-word instance
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    chk("jmp_pc1", pc8, 1);
    jmp_ce = 1'b1; jmp_addr = 8'd5;
    chk("jmp_no_bubble", op8, 4'h3);
    cyc(); jmp_ce = 1'b0;
    chk("jmp_pc5", pc8, 5);
    chk("jmp_retired", ret8, 2);
    chk("jmp_running", run8, 1);
    // self-loop jump
    rst = 1'b1; cyc(); rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    chk("self_pc2", pc8, 2);
    jmp_ce = 1'b1; jmp_addr = 8'd2;
    cyc(); jmp_ce = 1'b0;
    chk("self_halted", hlt8, 1);
    chk("self_pc", pc8, 2);
    chk("self_opcode", op8, 4'hF);
    chk("self_retired", ret8, 3);
    // out-of-range jump
    start = 1'b1; cyc(); start = 1'b0;
    chk("oor_restart_pc", pc8, 0);
    chk("oor_restart_retired", ret8, 0);
    jmp_ce = 1'b1; jmp_addr = 8'd9;
    cyc(); jmp_ce = 1'b0;
    chk("oor_halted", hlt8, 1);
    chk("oor_err", err8, 1);
    chk("oor_pc", pc8, 0);
    chk("oor_retired", ret8, 1);
    cyc();
    chk("oor_err_sticky", err8, 1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("oor_clear_err", err8, 0);
    chk("oor_clear_pc", pc8, 0);
    chk("oor_clear_running", run8, 1);
    // abort beats start mid-run
    cyc(); cyc(); cyc();
    chk("abort_pc3", pc8, 3);
    abort = 1'b1; start = 1'b1; #1;
    chk("abort_opcode", op8, 4'hF);
    chk("abort_argument", arg8, 0);
    cyc(); abort = 1'b0; start = 1'b0;
    chk("abort_halted", hlt8, 1);
    chk("abort_running", run8, 0);
    chk("abort_retired", ret8, 3);
    chk("abort_pc", pc8, 3);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("abort_rst_halted", hlt8, 0);
    chk("abort_rst_running", run8, 0);
    chk("abort_rst_pc", pc8, 0);
    // reset during run overrides start and bubbles next cycle
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    rst = 1'b1; start = 1'b1; cyc(); rst = 1'b0; start = 1'b0;
    chk("midrst_opcode", op8, 4'hF);
    chk("midrst_running", run8, 0);
    chk("midrst_retired", ret8, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
